fact_regbank_mc: RTL
====================

Name: fact_regbank_mc

Overview:
Multi-channel, fully registered slave register bank that fronts N_CH factorial cores on the shared s_* bus. Each channel has its own register window containing start, clear, status, interrupt-enable, operand and 128-bit result registers. The block adds behaviour the single-channel decoder lacks: one-cycle command pulses, result capture on done, busy-write protection with an error flag, registered read data with a valid strobe, and an aggregated interrupt.

Parameters:
N_CH, 2, number of factorial channels (1..8)
DATA_W, 64, bus and operand width; result is 2*DATA_W
BASE_ADDR, 16'h7000, byte address of channel 0 window
CH_STRIDE, 16'h0040, byte stride between channel windows (power of two, >= 0x40)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
s_sel  in  1  bus select
s_wr  in  1  1 = write, 0 = read
s_addr  in  16  byte address; bits [2:0] ignored
s_din  in  DATA_W  write data
s_dout  out  DATA_W  registered read data
s_rvalid  out  1  one-cycle strobe marking s_dout valid
ch_start  out  N_CH  per-channel start pulse
ch_clear  out  N_CH  per-channel clear pulse
ch_operand  out  N_CH*DATA_W  per-channel operand; channel i occupies [i*DATA_W +: DATA_W]
ch_busy  in  N_CH  core calculating
ch_done  in  N_CH  core result ready (level)
ch_result  in  N_CH*2*DATA_W  core results; channel i occupies [i*2*DATA_W +: 2*DATA_W]
irq_vec  out  N_CH  per-channel pending interrupt
irq  out  1  OR of irq_vec

Behaviour:
- Reset: reset_n is synchronous, active-low. At the first clk edge with reset_n=0, every register and output goes to its reset value: all outputs 0, operand 0, intren 0, done_latch 0, err 0, result_h 0, result_l 1.
- Decode: ch = (s_addr - BASE_ADDR) / CH_STRIDE; off = s_addr[5:3]. The access is a hit only if ch < N_CH and off <= 6. A global IRQ_STATUS register sits at BASE_ADDR + N_CH*CH_STRIDE (read-only).
- Register map per channel:
  - 0x00 OPSTART (W): s_din[0]=1 with ch_busy=0 -> ch_start[ch]=1 for exactly the next cycle.
  - 0x08 OPCLEAR (W): s_din[0]=1 -> ch_clear[ch]=1 for exactly the next cycle; clears done_latch and err.
  - 0x10 STATUS (R): {0.., err, done_latch, ch_busy}.
  - 0x18 INTREN (R/W): bit 0 only.
  - 0x20 OPERAND (R/W).
  - 0x28 RESULT_H (R).
  - 0x30 RESULT_L (R).
- Busy protection: a write to OPSTART or OPERAND while ch_busy=1 is dropped and sets err=1. It produces no start pulse and leaves the operand unchanged.
- Result capture: on a ch_done rising edge (0->1, detected against a registered copy), result_h and result_l load ch_result and done_latch sets. The shadow registers hold until the next rising edge or reset; OPCLEAR does not zero them.
- Simultaneous done rise and OPCLEAR in the same cycle: the set wins, so done_latch=1 and err is cleared.
- Reads: s_sel=1 and s_wr=0 -> next cycle s_rvalid=1 and s_dout = register value (latency 1).
  - A miss, or a read of a write-only register, returns 0 but still pulses s_rvalid.
  - s_dout holds its value when s_rvalid=0.
  - Back-to-back reads produce back-to-back valid data.
- Writes: take effect at the clk edge where s_sel=1 and s_wr=1. Writes to read-only registers or to a miss address are ignored with no side effects.
- Interrupts: irq_vec[i] and irq are registered.
  - irq_vec[i] = done_latch[i] & intren[i].
  - irq = |irq_vec.
  - Both update one cycle after the contributing change.
- Reset mid-operation: pending pulses are cancelled and no ch_start is emitted in the cycle following reset. Core outputs seen during reset do not set done_latch.
- Channels are independent. An access to channel i never alters the state of channel j.

Test Plan:
- Reset: reset_n=0 for 2 cycles -> all outputs 0; read 0x7030 returns 1 with s_rvalid=1 one cycle after the request.
- Start handshake: write 0x7020=5, then 0x7000=1 with busy=0 -> ch_start[0] high for exactly 1 cycle, ch_operand[0]=5. Repeat on ch 1 (0x7060/0x7040) -> ch_start[1] only.
- Busy drop: ch_busy[0]=1, write 0x7000=1 and 0x7020=9 -> no ch_start, operand stays 5, STATUS read = 0x5. Then OPCLEAR -> ch_clear pulse, STATUS = 0x1.
- Result/IRQ: INTREN=1, ch_done[1] rises with ch_result[1]={64'h0,64'd120} -> RESULT_L (0x7070)=120, RESULT_H=0, irq_vec=2'b10, irq=1 one cycle later. OPCLEAR clears irq while RESULT_L stays 120.
- Race and decode: OPCLEAR in the same cycle as a done rise -> done_latch=1. Read 0x7200 (miss) -> s_dout=0, s_rvalid=1. Read IRQ_STATUS at 0x7080 returns irq_vec.
- Mid-op reset: assert reset_n=0 in the cycle after an OPSTART write -> no ch_start pulse, all state at reset values.

Source files
------------

// File: rtl/fact_regbank_mc.sv
`default_nettype none
// ============================================================================
// Module   : fact_regbank_mc
// Purpose  : Multi-channel slave register bank fronting N_CH factorial cores
//            on the shared s_* bus. Each channel owns a register window with
//            start/clear command pulses, status, interrupt enable, operand and
//            a captured 2*DATA_W result. Read data is registered with a
//            one-cycle valid strobe. Per-channel interrupts are aggregated.
// Ports    : clk, reset_n (sync, active-low)
//            s_sel/s_wr/s_addr/s_din  -> bus request
//            s_dout/s_rvalid          <- registered read response
//            ch_start/ch_clear        <- one-cycle command pulses per channel
//            ch_operand               <- per-channel operand (DATA_W each)
//            ch_busy/ch_done/ch_result-> core status and 2*DATA_W results
//            irq_vec/irq              <- registered interrupt outputs
// Revision : 1.0 - initial release
// ============================================================================
module fact_regbank_mc #(
    parameter int          N_CH      = 2,
    parameter int          DATA_W    = 64,
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter logic [15:0] CH_STRIDE = 16'h0040
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_sel,
    input  logic                       s_wr,
    input  logic [15:0]                s_addr,
    input  logic [DATA_W-1:0]          s_din,
    output logic [DATA_W-1:0]          s_dout,
    output logic                       s_rvalid,
    output logic [N_CH-1:0]            ch_start,
    output logic [N_CH-1:0]            ch_clear,
    output logic [N_CH*DATA_W-1:0]     ch_operand,
    input  logic [N_CH-1:0]            ch_busy,
    input  logic [N_CH-1:0]            ch_done,
    input  logic [N_CH*2*DATA_W-1:0]   ch_result,
    output logic [N_CH-1:0]            irq_vec,
    output logic                       irq
);

    localparam int          c_STRIDE_SH = $clog2(CH_STRIDE);
    localparam logic [15:0] c_IRQ_ADDR  = BASE_ADDR + 16'(N_CH) * CH_STRIDE;

    localparam logic [2:0] c_OFF_OPSTART  = 3'd0;
    localparam logic [2:0] c_OFF_OPCLEAR  = 3'd1;
    localparam logic [2:0] c_OFF_STATUS   = 3'd2;
    localparam logic [2:0] c_OFF_INTREN   = 3'd3;
    localparam logic [2:0] c_OFF_OPERAND  = 3'd4;
    localparam logic [2:0] c_OFF_RESULT_H = 3'd5;
    localparam logic [2:0] c_OFF_RESULT_L = 3'd6;

    // ------------------------------------------------------------------------
    // Address decode. Addresses below BASE_ADDR wrap to a huge channel index
    // and therefore miss naturally.
    // ------------------------------------------------------------------------
    logic [15:0] w_ch;
    logic [2:0]  w_off;
    logic        w_hit;
    logic        w_irq_hit;
    logic        w_rd;
    logic        w_wr;

    assign w_ch      = (s_addr - BASE_ADDR) >> c_STRIDE_SH;
    assign w_off     = s_addr[5:3];
    assign w_hit     = (w_ch < 16'(N_CH)) && (w_off <= c_OFF_RESULT_L);
    assign w_irq_hit = (s_addr[15:3] == c_IRQ_ADDR[15:3]);
    assign w_rd      = s_sel & ~s_wr;
    assign w_wr      = s_sel &  s_wr;

    logic [DATA_W-1:0] w_ch_rdata [N_CH];
    logic [N_CH-1:0]   w_irq_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] r_operand;
            logic [DATA_W-1:0] r_res_h;
            logic [DATA_W-1:0] r_res_l;
            logic              r_intren;
            logic              r_done_latch;
            logic              r_err;
            logic              r_done_q;
            logic              r_start;
            logic              r_clear;
            logic              r_irq_vec;

            logic              w_sel;
            logic              w_wr_start;
            logic              w_wr_clear;
            logic              w_wr_intren;
            logic              w_wr_operand;
            logic              w_rise;
            logic [DATA_W-1:0] w_rd_mux;

            assign w_sel        = w_hit && (w_ch == 16'(gi));
            assign w_wr_start   = w_wr & w_sel & (w_off == c_OFF_OPSTART);
            assign w_wr_clear   = w_wr & w_sel & (w_off == c_OFF_OPCLEAR) & s_din[0];
            assign w_wr_intren  = w_wr & w_sel & (w_off == c_OFF_INTREN);
            assign w_wr_operand = w_wr & w_sel & (w_off == c_OFF_OPERAND);
            assign w_rise       = ch_done[gi] & ~r_done_q;
            assign w_irq_next[gi] = r_done_latch & r_intren;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_operand    <= '0;
                    r_res_h      <= '0;
                    r_res_l      <= DATA_W'(1);
                    r_intren     <= 1'b0;
                    r_done_latch <= 1'b0;
                    r_err        <= 1'b0;
                    r_start      <= 1'b0;
                    r_clear      <= 1'b0;
                    r_irq_vec    <= 1'b0;
                    // Track done through reset so a level already high when
                    // reset releases is not mistaken for a fresh completion.
                    r_done_q     <= ch_done[gi];
                end else begin
                    r_done_q  <= ch_done[gi];
                    r_start   <= w_wr_start & s_din[0] & ~ch_busy[gi];
                    r_clear   <= w_wr_clear;
                    r_irq_vec <= w_irq_next[gi];

                    // Writes that would disturb a running core are dropped
                    // and flagged instead.
                    if (w_wr_start && ch_busy[gi]) begin
                        r_err <= 1'b1;
                    end
                    if (w_wr_operand) begin
                        if (ch_busy[gi]) begin
                            r_err <= 1'b1;
                        end else begin
                            r_operand <= s_din;
                        end
                    end
                    if (w_wr_intren) begin
                        r_intren <= s_din[0];
                    end
                    if (w_wr_clear) begin
                        r_done_latch <= 1'b0;
                        r_err        <= 1'b0;
                    end
                    // Placed after the clear so a same-cycle completion wins.
                    if (w_rise) begin
                        r_done_latch <= 1'b1;
                        r_res_h      <= ch_result[gi*2*DATA_W+DATA_W +: DATA_W];
                        r_res_l      <= ch_result[gi*2*DATA_W +: DATA_W];
                    end
                end
            end

            always_comb begin
                w_rd_mux = '0;
                case (w_off)
                    c_OFF_STATUS:   w_rd_mux = {{(DATA_W-3){1'b0}}, r_err, r_done_latch, ch_busy[gi]};
                    c_OFF_INTREN:   w_rd_mux = {{(DATA_W-1){1'b0}}, r_intren};
                    c_OFF_OPERAND:  w_rd_mux = r_operand;
                    c_OFF_RESULT_H: w_rd_mux = r_res_h;
                    c_OFF_RESULT_L: w_rd_mux = r_res_l;
                    default:        w_rd_mux = '0;
                endcase
            end

            assign w_ch_rdata[gi]                   = w_rd_mux;
            assign ch_start[gi]                     = r_start;
            assign ch_clear[gi]                     = r_clear;
            assign ch_operand[gi*DATA_W +: DATA_W]  = r_operand;
            assign irq_vec[gi]                      = r_irq_vec;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read response and aggregated interrupt
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_dout;
    logic              r_rvalid;
    logic              r_irq;

    always_comb begin
        w_rdata = '0;
        if (w_irq_hit) begin
            w_rdata = {{(DATA_W-N_CH){1'b0}}, irq_vec};
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_hit && (w_ch == 16'(k))) begin
                    w_rdata = w_ch_rdata[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_dout <= w_rdata;
            end
            // Built from the same terms as irq_vec so both move together.
            r_irq <= |w_irq_next;
        end
    end

    assign s_dout   = r_dout;
    assign s_rvalid = r_rvalid;
    assign irq      = r_irq;

endmodule
`default_nettype wire
